// File: rtl/systolic_pkg.sv
// Shared types and size helpers for the systolic array edge buffers.
// Optional output clamp in result_serializer is enabled with `define OUTPUT_RELU_EN.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } deskew_state_t;

    // Number of beats a full skewed wavefront occupies on the array edge.
    function automatic int skew_beats(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int out_count(input int n);
        return n * n;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/result_serializer.sv
// Row-major read-out of the deskewed matrix over a valid/ready handshake.
// With `define OUTPUT_RELU_EN negative elements are clamped to zero on the way out.
module result_serializer
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 i_active,
    input  logic                                 i_ready,
    input  logic signed [DATA_WIDTH-1:0]         i_elem,
    output logic [cnt_width(MATRIX_SIZE)-1:0]    o_rd_row,
    output logic [cnt_width(MATRIX_SIZE)-1:0]    o_rd_col,
    output logic                                 o_valid,
    output logic signed [DATA_WIDTH-1:0]         o_data,
    output logic                                 o_last,
    output logic                                 o_done
);

    localparam int N  = MATRIX_SIZE;
    localparam int RW = cnt_width(N);
    localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

    logic [RW-1:0]                r_row;
    logic [RW-1:0]                r_col;
    logic                         w_fire;
    logic                         w_last;
    logic signed [DATA_WIDTH-1:0] w_val;

    assign w_fire = i_active && i_ready;
    assign w_last = i_active && (r_row == LAST_IDX) && (r_col == LAST_IDX);

    // The index wraps back to 0,0 on the final transfer, ready for the next matrix.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_fire) begin
            if (r_col == LAST_IDX) begin
                r_col <= '0;
                r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

`ifdef OUTPUT_RELU_EN
    assign w_val = (i_elem < 0) ? '0 : i_elem;
`else
    assign w_val = i_elem;
`endif

    assign o_rd_row = r_row;
    assign o_rd_col = r_col;
    assign o_valid  = i_active;
    assign o_data   = i_active ? w_val : '0;
    assign o_last   = w_last;
    assign o_done   = w_fire && w_last;

endmodule

// File: rtl/result_deskew_buffer.sv
// Captures the skewed result wavefront from the array bottom edge and replays it row-major.
// Build with `define OUTPUT_RELU_EN to clamp negative outputs to zero (storage stays raw).
module result_deskew_buffer
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_row [MATRIX_SIZE-1:0],
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         busy
);

    localparam int N          = MATRIX_SIZE;
    localparam int SKEW_BEATS = skew_beats(N);
    localparam int BW         = cnt_width(SKEW_BEATS);
    localparam int RW         = cnt_width(N);

    deskew_state_t                r_state;
    deskew_state_t                w_next;
    logic [BW-1:0]                r_beat;
    logic signed [DATA_WIDTH-1:0] r_mem [N][N];

    logic                         w_cap;
    logic                         w_drain;
    logic                         w_last_beat;
    logic                         w_done;
    logic [RW-1:0]                w_rd_row;
    logic [RW-1:0]                w_rd_col;
    logic signed [DATA_WIDTH-1:0] w_elem;

    assign w_last_beat = (r_beat == BW'(SKEW_BEATS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // IDLE treats its first valid beat as t=0, so IDLE and CAPTURE share the exit test.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = w_last_beat ? DRAIN : CAPTURE;
            CAPTURE: if (in_valid && w_last_beat) w_next = DRAIN;
            DRAIN:   if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state != DRAIN);
        busy     = (r_state != IDLE);
        w_drain  = (r_state == DRAIN);
        w_cap    = in_ready && in_valid;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      r_beat <= '0;
        else if (w_cap) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
    end

    // Column c carries row r of the result on beat t = r + c; all other lanes are discarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    r_mem[r][c] <= '0;
        end else if (w_cap) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    if (int'(r_beat) == r + c)
                        r_mem[r][c] <= in_row[c];
        end
    end

    assign w_elem = r_mem[w_rd_row][w_rd_col];

    result_serializer #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rstn     (rstn),
        .i_active (w_drain),
        .i_ready  (out_ready),
        .i_elem   (w_elem),
        .o_rd_row (w_rd_row),
        .o_rd_col (w_rd_col),
        .o_valid  (out_valid),
        .o_data   (out_data),
        .o_last   (out_last),
        .o_done   (w_done)
    );

endmodule

// File: tb/tb_result_deskew_buffer.sv
// Bench for result_deskew_buffer: matrix-level model, skewed beat generation, row-major expectations.
module tb_result_deskew_buffer;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int NN = N * N;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] in_row [N-1:0];
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;

    logic signed [DW-1:0] mat [N][N];
    logic [DW-1:0]        exp_q [$];

    always #5 clk = ~clk;

    result_deskew_buffer #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_row    (in_row),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    function automatic logic [DW-1:0] xform(input logic signed [DW-1:0] v);
`ifdef OUTPUT_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic rand_mat();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = DW'($urandom);
    endtask

    // Feeds mat as a skewed wavefront; optional stalls between beats.
    task automatic load(input int stall_after, input int stall_cycles, input int rnd_stall);
        exp_q.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_q.push_back(xform(mat[r][c]));
        for (int t = 0; t < 2 * N - 1; t++) begin
            int nst;
            @(negedge clk);
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                int r = t - i;
                in_row[i] = (r >= 0 && r < N) ? mat[r][i] : DW'($urandom);
            end
            nst = 0;
            if (t < 2 * N - 2) begin
                if (t == stall_after) nst = stall_cycles;
                else if (rnd_stall != 0) nst = $urandom_range(0, 2);
            end
            for (int s = 0; s < nst; s++) begin
                @(negedge clk);
                chk("busy_stall", busy, 1);
                in_valid = 1'b0;
                for (int i = 0; i < N; i++) in_row[i] = DW'($urandom);
            end
        end
    endtask

    // rmode: 0 ready always, 1 fixed toggle pattern, 2 random ready.
    task automatic drain(input int junk, input int stop, input int rmode);
        int k = 0;
        int cyc = 0;
        int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        logic rdy;
        while (k < stop && cyc < 200) begin
            @(negedge clk);
            chk("out_valid", out_valid, 1);
            chk("in_ready_drain", in_ready, 0);
            chk("busy_drain", busy, 1);
            chk("out_data", $unsigned(out_data), exp_q[k]);
            chk("out_last", out_last, (k == NN - 1));
            in_valid = (junk != 0);
            if (junk != 0)
                for (int i = 0; i < N; i++) in_row[i] = 16'sd9;
            if (rmode == 0)      rdy = 1'b1;
            else if (rmode == 1) rdy = (cyc < 7) ? pat[cyc][0] : 1'b1;
            else                 rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (rdy) k++;
            cyc++;
        end
        if (k < stop) chk("drain_timeout", k, stop);
        if (stop == NN && k == NN) begin
            @(negedge clk);
            chk("idle_valid", out_valid, 0);
            chk("idle_data", $unsigned(out_data), 0);
            chk("idle_last", out_last, 0);
            chk("idle_busy", busy, 0);
            chk("idle_in_ready", in_ready, 1);
            out_ready = 1'b0;
            in_valid  = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) in_row[i] = '0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", $unsigned(out_data), 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk) rstn = 1'b1;

        // Nominal N=2
        mat = '{'{16'sd1, 16'sd2}, '{16'sd3, 16'sd4}};
        load(-1, 0, 0);
        drain(0, NN, 0);

        // Two-cycle input stall between beats 1 and 2
        load(1, 2, 0);
        drain(0, NN, 0);

        // Output back-pressure pattern
        load(-1, 0, 0);
        drain(0, NN, 1);

        // Junk beats offered during drain, then a new matrix
        mat = '{'{16'sd5, 16'sd6}, '{16'sd7, 16'sd8}};
        load(-1, 0, 0);
        drain(1, NN, 0);
        mat = '{'{16'sd11, 16'sd12}, '{16'sd13, 16'sd14}};
        load(-1, 0, 0);
        drain(0, NN, 0);

        // Async reset after two accepted outputs
        rand_mat();
        load(-1, 0, 0);
        drain(0, 2, 0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_data", $unsigned(out_data), 0);
        chk("abort_last", out_last, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        out_ready = 1'b0;
        @(negedge clk) rstn = 1'b1;
        rand_mat();
        load(-1, 0, 0);
        drain(0, NN, 0);

        // Signed values through the optional clamp
        mat = '{'{-16'sd5, 16'sd7}, '{16'sd0, -16'sd1}};
        load(-1, 0, 0);
        drain(0, NN, 0);

        // Randomized matrices, stalls and ready
        for (int it = 0; it < 8; it++) begin
            rand_mat();
            load(-1, 0, 1);
            drain(0, NN, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_deskew_buffer.md
Name: result_deskew_buffer

Overview:
Receive-side counterpart of the weight skewing buffer. It accepts the diagonally skewed result wavefront leaving the bottom edge of the MATRIX_SIZE x MATRIX_SIZE systolic array over 2*MATRIX_SIZE-1 beats. It then reassembles the result matrix and streams it out one element per transfer, in row-major order, over a valid/ready handshake. It sits between the array output edge and the result writer or host interface.

Parameters:
MATRIX_SIZE, 2, array dimension N; result matrix is N x N
DATA_WIDTH, 16, signed element width on input and output

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  skewed wavefront beat present on in_row
in_row  input  N x DATA_WIDTH signed (unpacked array [N-1:0])  one element per array column for this beat
in_ready  output  1  block can accept a wavefront beat
out_valid  output  1  out_data holds a valid result element
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  DATA_WIDTH signed  serialized result element, row-major
out_last  output  1  high with the final element (index N*N-1)
busy  output  1  high in CAPTURE or DRAIN

Behaviour:
- Reset (async, rstn=0): state=IDLE; beat counter, read row and read col = 0; storage cleared to 0; out_valid=0; out_data=0; out_last=0; busy=0; in_ready=1.
- States: IDLE, CAPTURE, DRAIN.
- IDLE: in_ready=1. in_valid=1 is treated as beat t=0 and is captured; the block moves to CAPTURE, or directly to DRAIN if SKEW_BEATS==1 (N=1).
- CAPTURE: in_ready=1. Each beat with in_valid=1 at beat index t:
  - For each column i where 0 <= t-i < N, store result[t-i][i] <= in_row[i].
  - Elements outside that window are don't-care and are discarded.
  - t increments on each beat.
- Beats with in_valid=0 are stalls: no state change, no capture.
- After beat t=2N-2 is captured, the next state is DRAIN. in_ready drops in the cycle after the last beat.
- DRAIN: in_ready=0, and in_valid is ignored. out_valid=1.
  - out_data = result[rd_row][rd_col] after the optional transform. It is driven from a registered index and is held stable while out_ready=0.
  - On out_valid && out_ready, advance: rd_col+1; on rd_col==N-1, wrap to 0 and rd_row+1.
  - out_last=1 when rd_row==N-1 and rd_col==N-1.
  - The transfer with out_last ends DRAIN. The next cycle is IDLE, with out_valid=0, counters reset to 0 and storage retained.
- Whenever out_valid=0, out_data=0 and out_last=0.
- Latency: the first element is valid in the cycle after the final capture beat. With out_ready held high, the N*N elements leave on consecutive cycles.
- Back-pressure: out_ready may drop at any time, including on the last element. Nothing is lost or duplicated.
- Asserting rstn mid-CAPTURE or mid-DRAIN aborts immediately: reset values are restored and partial data is discarded.
- Width: no arithmetic on data; values pass through bit-exact. Counters are sized with $clog2 of 2N-1 and of N, minimum 1 bit.

Optional Feature:
- Macro OUTPUT_RELU_EN.
- When defined: out_data = (element < 0) ? 0 : element, applied combinationally at the output. Storage keeps the raw values.
- When undefined: out_data is the raw stored element.
- Handshake and timing are identical in both cases.

Decomposition:
- Shared package (systolic_pkg) holds:
  - state enum deskew_state_t {IDLE, CAPTURE, DRAIN}
  - SKEW_BEATS = 2*MATRIX_SIZE-1 and OUT_COUNT = MATRIX_SIZE*MATRIX_SIZE, as functions of the parameter
- One natural sub-module: result_serializer. It holds the rd_row/rd_col counters, the valid/ready handshake, out_last and the OUTPUT_RELU_EN transform. The top keeps the capture FSM and storage.

Test Plan:
- N=2 nominal:
  - Stimulus: beats {col0=1, col1=X}, {col0=3, col1=2}, {col0=X, col1=4}, out_ready=1.
  - Response: out_data 1, 2, 3, 4 on four consecutive cycles; out_last only with 4; busy falls one cycle later.
- Input stalls: same N=2 data with in_valid=0 for 2 cycles between beats 1 and 2 -> identical output 1, 2, 3, 4; no extra captures.
- Output back-pressure: out_ready toggles 1,0,0,1,0,1,1 -> each element held stable while out_ready=0; sequence 1, 2, 3, 4 with no drops or duplicates; out_last held until accepted.
- in_valid during DRAIN: drive beats of value 9 while draining -> in_ready=0, output unaffected. The next matrix is captured correctly after return to IDLE.
- Async reset mid-DRAIN: drop rstn after 2 outputs -> out_valid=0, out_data=0 and in_ready=1 immediately. A fresh N=2 load then outputs its own four values.
- OUTPUT_RELU_EN defined, N=2 with values -5, 7, 0, -1 -> out_data 0, 7, 0, 0. Undefined -> -5, 7, 0, -1.
